// File: rtl/ram_rr_arbiter.sv
// Two-port round-robin arbiter/sequencer in front of a 64x8 single-port RAM with 2-cycle read return.
// Define RAM_ARB_CLEAR_ON_RESET_EN to zero-fill the RAM after every reset before accepting requests.
module ram_rr_arbiter #(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 6,
    parameter int DEPTH  = 64
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              a_valid,
    output logic              a_ready,
    input  logic              a_we,
    input  logic [ADDR_W-1:0] a_addr,
    input  logic [DATA_W-1:0] a_wdata,
    output logic              a_rvalid,
    output logic [DATA_W-1:0] a_rdata,
    input  logic              b_valid,
    output logic              b_ready,
    input  logic              b_we,
    input  logic [ADDR_W-1:0] b_addr,
    input  logic [DATA_W-1:0] b_wdata,
    output logic              b_rvalid,
    output logic [DATA_W-1:0] b_rdata,
    output logic              ram_we,
    output logic [DATA_W-1:0] ram_data,
    output logic [ADDR_W-1:0] ram_write_addr,
    output logic [ADDR_W-1:0] ram_read_addr,
    input  logic [DATA_W-1:0] ram_q,
    output logic              busy
);

    if (DEPTH != 2 ** ADDR_W) begin : g_depth_check
        $error("ram_rr_arbiter: DEPTH must equal 2**ADDR_W");
    end

    logic              run;
    logic              clearing;
    logic [ADDR_W-1:0] clr_addr;
    logic              ptr;
    logic              grant_a;
    logic              grant_b;
    logic              wr_grant;
    logic              rd_grant;
    logic [ADDR_W-1:0] sel_addr;
    logic [DATA_W-1:0] sel_wdata;
    logic [ADDR_W-1:0] rd_addr_q;
    logic              rd_pend;
    logic              rd_owner;

`ifdef RAM_ARB_CLEAR_ON_RESET_EN
    typedef enum logic {ST_CLEAR, ST_RUN} state_t;
    state_t state;
    state_t state_next;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state    <= ST_CLEAR;
            clr_addr <= '0;
        end else begin
            state <= state_next;
            if (state == ST_CLEAR)
                clr_addr <= clr_addr + 1'b1;
        end
    end

    // Outputs are qualified with rst_n so nothing is written or granted while reset is held.
    always_comb begin
        state_next = state;
        clearing   = 1'b0;
        run        = 1'b0;
        case (state)
            ST_CLEAR: begin
                clearing = rst_n;
                if (clr_addr == ADDR_W'(DEPTH - 1))
                    state_next = ST_RUN;
            end
            ST_RUN:  run = rst_n;
            default: state_next = ST_CLEAR;
        endcase
    end

    assign busy = clearing;
`else
    assign run      = rst_n;
    assign clearing = 1'b0;
    assign clr_addr = '0;
    assign busy     = 1'b0;
`endif

    // On contention the pointer picks the winner; a lone requester always wins.
    assign grant_a = run && a_valid && (!b_valid || !ptr);
    assign grant_b = run && b_valid && (!a_valid || ptr);
    assign a_ready = grant_a;
    assign b_ready = grant_b;

    assign sel_addr  = grant_a ? a_addr : b_addr;
    assign sel_wdata = grant_a ? a_wdata : b_wdata;
    assign wr_grant  = (grant_a && a_we) || (grant_b && b_we);
    assign rd_grant  = (grant_a && !a_we) || (grant_b && !b_we);

    always_comb begin
        ram_we         = clearing || wr_grant;
        ram_write_addr = clearing ? clr_addr : sel_addr;
        ram_data       = clearing ? '0 : sel_wdata;
        ram_read_addr  = rd_grant ? sel_addr : rd_addr_q;
    end

    // rd_pend/rd_owner track the read whose data appears on ram_q this cycle.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            ptr       <= 1'b0;
            rd_addr_q <= '0;
            rd_pend   <= 1'b0;
            rd_owner  <= 1'b0;
            a_rvalid  <= 1'b0;
            b_rvalid  <= 1'b0;
            a_rdata   <= '0;
            b_rdata   <= '0;
        end else begin
            if (grant_a)
                ptr <= 1'b1;
            else if (grant_b)
                ptr <= 1'b0;
            if (rd_grant)
                rd_addr_q <= sel_addr;
            rd_pend  <= rd_grant;
            rd_owner <= grant_b;
            a_rvalid <= rd_pend && !rd_owner;
            b_rvalid <= rd_pend && rd_owner;
            if (rd_pend && !rd_owner)
                a_rdata <= ram_q;
            if (rd_pend && rd_owner)
                b_rdata <= ram_q;
        end
    end

endmodule
